// File: rtl/entrada_chaves.sv
// entrada_chaves: synchronizes switches and push button, debounces the button, and returns one switch word per press.
// Latency: Pronto rises the cycle after the (2 + DEBOUNCE_CICLOS)-th consecutive low sample of Botao while waiting.
// Backpressure: a level request (CTRLEntrada) stalls until the Pronto strobe; a new capture needs a full release and a new press.
// Optional macro ENTRADA_SINAL_EN: sign-extend the captured word from Chaves[LARGURA_CHAVES-1] (default: zero-extend).
module entrada_chaves #(
    parameter int LARGURA_CHAVES  = 16,
    parameter int DEBOUNCE_CICLOS = 500000
) (
    input  logic                      CLK,
    input  logic                      RSTn,
    input  logic [LARGURA_CHAVES-1:0] Chaves,
    input  logic                      Botao,
    input  logic                      CTRLEntrada,
    output logic [31:0]               DadoSaida,
    output logic                      Pronto,
    output logic                      Aguardando
);

    localparam int CNT_W = $clog2(DEBOUNCE_CICLOS);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        ESPERA = 2'd1,
        SOLTAR = 2'd2
    } estado_t;

    // Synchronizer stages; the button idles released (high).
    logic                      botao_s1_q;
    logic                      botao_s2_q;
    logic [LARGURA_CHAVES-1:0] chaves_s1_q;
    logic [LARGURA_CHAVES-1:0] chaves_s2_q;

    // Debounce state.
    logic             estavel_q;
    logic             estavel_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             evento_press;
    logic             evento_solta;

    // Handshake state and registered outputs.
    estado_t     estado_q;
    logic [31:0] dado_q;
    logic        pronto_q;
    logic        aguardando_q;

    // Extended switch word presented to the capture register.
    logic        sinal;
    logic [31:0] dado_ext_d;

    // Two-stage synchronizers on the asynchronous board inputs.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            botao_s1_q  <= 1'b1;
            botao_s2_q  <= 1'b1;
            chaves_s1_q <= '0;
            chaves_s2_q <= '0;
        end else begin
            botao_s1_q  <= Botao;
            botao_s2_q  <= botao_s1_q;
            chaves_s1_q <= Chaves;
            chaves_s2_q <= chaves_s1_q;
        end
    end

    // Debounce next state: any sample agreeing with the stable level restarts the count.
    always_comb begin
        estavel_d = estavel_q;
        cnt_d     = cnt_q;
        if (botao_s2_q == estavel_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            estavel_d = ~estavel_q;
            cnt_d     = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Events are the edges on which the stable level flips.
    assign evento_press = estavel_q & ~estavel_d;
    assign evento_solta = ~estavel_q & estavel_d;

    // Debounce state registers.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            estavel_q <= 1'b1;
            cnt_q     <= '0;
        end else begin
            estavel_q <= estavel_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef ENTRADA_SINAL_EN
    assign sinal = chaves_s2_q[LARGURA_CHAVES-1];
`else
    assign sinal = 1'b0;
`endif

    // Extend the synchronized switch word to the 32-bit datapath width.
    always_comb begin
        dado_ext_d                     = {32{sinal}};
        dado_ext_d[LARGURA_CHAVES-1:0] = chaves_s2_q;
    end

    // Request/press handshake FSM with registered outputs. A press already held when the
    // request arrives routes through SOLTAR, so only a fresh press is ever captured.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            estado_q     <= OCIOSO;
            dado_q       <= '0;
            pronto_q     <= 1'b0;
            aguardando_q <= 1'b0;
        end else begin
            pronto_q <= 1'b0;
            case (estado_q)
                OCIOSO: begin
                    if (CTRLEntrada) begin
                        if (estavel_q) begin
                            estado_q     <= ESPERA;
                            aguardando_q <= 1'b1;
                        end else begin
                            estado_q <= SOLTAR;
                        end
                    end
                end
                ESPERA: begin
                    // A dropped request wins over a simultaneous press.
                    if (!CTRLEntrada) begin
                        estado_q     <= OCIOSO;
                        aguardando_q <= 1'b0;
                    end else if (evento_press) begin
                        dado_q       <= dado_ext_d;
                        pronto_q     <= 1'b1;
                        aguardando_q <= 1'b0;
                        estado_q     <= SOLTAR;
                    end
                end
                SOLTAR: begin
                    if (evento_solta) begin
                        estado_q <= OCIOSO;
                    end
                end
                default: begin
                    estado_q     <= OCIOSO;
                    aguardando_q <= 1'b0;
                end
            endcase
        end
    end

    assign DadoSaida  = dado_q;
    assign Pronto     = pronto_q;
    assign Aguardando = aguardando_q;

endmodule
